// File: rtl/norm_shift.sv
// Iterative signed normalizer: strips redundant sign bits, up to STEP per cycle, and returns the count.
// Optional NORM_SHIFT_ZERO_EN adds norm_zero_o and a single-step early exit for a zero operand.
module norm_shift #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned STEP  = 4,
   localparam int unsigned SW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             norm_valid_i,
   output logic             norm_ready_o,
   input  logic [WIDTH-1:0] norm_i,
   output logic             norm_valid_o,
   input  logic             norm_ready_i,
   output logic [WIDTH-1:0] norm_o,
   output logic [SW-1:0]    norm_sh_o
`ifdef NORM_SHIFT_ZERO_EN
   ,
   output logic             norm_zero_o
`endif
);

   localparam int unsigned KW     = $clog2(STEP + 1);
   localparam int unsigned CW     = SW + 1;
   localparam int unsigned MAX_SH = WIDTH - 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] work_q, work_d;
   logic [SW-1:0]    cnt_q, cnt_d;
   logic             ready_q, ready_d;
   logic             valid_q, valid_d;
`ifdef NORM_SHIFT_ZERO_EN
   logic             zero_q, zero_d;
`endif

   logic [KW-1:0]    lead;
   logic             run;
   logic [CW-1:0]    rem;
   logic [CW-1:0]    k;
   logic [CW-1:0]    cnt_nxt;

   // Redundant sign bits in the top STEP+1 bits, capped so the count never passes WIDTH-1.
   always_comb begin
      lead = '0;
      run  = 1'b1;
      for (int i = 1; i <= int'(STEP); i++) begin
         if (run && (work_q[WIDTH-1-i] == work_q[WIDTH-1])) begin
            lead = lead + KW'(1);
         end else begin
            run = 1'b0;
         end
      end
      rem     = CW'(MAX_SH) - CW'(cnt_q);
      k       = (CW'(lead) > rem) ? rem : CW'(lead);
      cnt_nxt = CW'(cnt_q) + k;
   end

   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      cnt_d   = cnt_q;
      ready_d = ready_q;
      valid_d = valid_q;
`ifdef NORM_SHIFT_ZERO_EN
      zero_d  = zero_q;
`endif
      case (state_q)
         IDLE: begin
            ready_d = 1'b1;
            valid_d = 1'b0;
            if (norm_valid_i) begin
               work_d  = norm_i;
               cnt_d   = '0;
               ready_d = 1'b0;
               state_d = BUSY;
`ifdef NORM_SHIFT_ZERO_EN
               zero_d  = 1'b0;
`endif
            end
         end
         BUSY: begin
`ifdef NORM_SHIFT_ZERO_EN
            if (work_q == '0) begin
               cnt_d   = SW'(MAX_SH);
               zero_d  = 1'b1;
               valid_d = 1'b1;
               state_d = DONE;
            end else begin
`endif
               work_d = work_q << k;
               cnt_d  = SW'(cnt_nxt);
               if ((k < CW'(STEP)) || (cnt_nxt == CW'(MAX_SH))) begin
                  valid_d = 1'b1;
                  state_d = DONE;
               end
`ifdef NORM_SHIFT_ZERO_EN
            end
`endif
         end
         DONE: begin
            // Result stays frozen until the downstream takes it.
            if (norm_ready_i) begin
               valid_d = 1'b0;
               ready_d = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            ready_d = 1'b1;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         work_q  <= '0;
         cnt_q   <= '0;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
`ifdef NORM_SHIFT_ZERO_EN
         zero_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
         valid_q <= valid_d;
`ifdef NORM_SHIFT_ZERO_EN
         zero_q  <= zero_d;
`endif
      end
   end

   assign norm_ready_o = ready_q;
   assign norm_valid_o = valid_q;
   assign norm_o       = work_q;
   assign norm_sh_o    = cnt_q;
`ifdef NORM_SHIFT_ZERO_EN
   assign norm_zero_o  = zero_q;
`endif

endmodule

// File: tb/tb_norm_shift.sv
// Scoreboard bench for norm_shift: directed vectors, backpressure, reset abort and a random sweep.
module tb_norm_shift;

   localparam int unsigned WIDTH = 64;
   localparam int unsigned STEP  = 4;
   localparam int unsigned SW    = $clog2(WIDTH);

   logic             clk = 1'b0;
   logic             rst;
   logic             norm_valid_i;
   logic             norm_ready_o;
   logic [WIDTH-1:0] norm_i;
   logic             norm_valid_o;
   logic             norm_ready_i;
   logic [WIDTH-1:0] norm_o;
   logic [SW-1:0]    norm_sh_o;
`ifdef NORM_SHIFT_ZERO_EN
   logic             norm_zero_o;
`endif

   norm_shift #(.WIDTH(WIDTH), .STEP(STEP)) dut (
      .clk          (clk),
      .rst          (rst),
      .norm_valid_i (norm_valid_i),
      .norm_ready_o (norm_ready_o),
      .norm_i       (norm_i),
      .norm_valid_o (norm_valid_o),
      .norm_ready_i (norm_ready_i),
      .norm_o       (norm_o),
      .norm_sh_o    (norm_sh_o)
`ifdef NORM_SHIFT_ZERO_EN
      ,
      .norm_zero_o  (norm_zero_o)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [WIDTH-1:0] x;
      logic [WIDTH-1:0] n;
      int               s;
      int               lat;
      logic             z;
      int               acc;
   } exp_t;

   exp_t sbq[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;
   int   last_handoff = 0;
   int   n_done = 0;
   bit   in_res = 0;
   bit   rand_rdy = 0;
   logic [WIDTH-1:0] held_n;
   logic [SW-1:0]    held_s;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: count bits below the MSB that match it, stopping at the first that differs.
   function automatic exp_t model(input logic [WIDTH-1:0] x);
      exp_t e;
      bit   run = 1;
      e.x = x;
      e.s = 0;
      for (int i = WIDTH - 2; i >= 0; i--) begin
         if (run && x[i] == x[WIDTH-1]) e.s++;
         else run = 0;
      end
      e.n   = x << e.s;
      e.lat = e.s / STEP + 1;
      e.z   = 1'b0;
`ifdef NORM_SHIFT_ZERO_EN
      if (x == '0) begin
         e.lat = 1;
         e.z   = 1'b1;
      end
`endif
      e.acc = 0;
      return e;
   endfunction

   // Operand already on norm_i/norm_valid_i: wait for acceptance, then log the expectation.
   task automatic hold_accept(input exp_t e);
      int guard = 0;
      bit ok = 0;
      while (!ok && guard < 300) begin
         @(negedge clk);
         if (norm_ready_o && !rst) ok = 1;
         else guard++;
      end
      if (!ok) begin
         chk("accept_timeout", 64'(guard), 64'(0));
      end else begin
         e.acc = cyc + 1;
         sbq.push_back(e);
      end
      @(posedge clk); #1;
      norm_valid_i = 1'b0;
      norm_i = {$urandom, $urandom};
   endtask

   task automatic send_exp(input exp_t e);
      @(posedge clk); #1;
      norm_valid_i = 1'b1;
      norm_i       = e.x;
      hold_accept(e);
   endtask

   task automatic send(input logic [WIDTH-1:0] x);
      send_exp(model(x));
   endtask

   function automatic exp_t vec(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] n,
                                input int s, input int lat);
      exp_t e;
      e.x = x; e.n = n; e.s = s; e.lat = lat; e.z = 1'b0; e.acc = 0;
      return e;
   endfunction

   task automatic wait_drain(input int budget);
      int t = 0;
      while ((sbq.size() != 0 || in_res || !norm_ready_o) && t < budget) begin
         @(negedge clk);
         t++;
      end
      if (t >= budget) chk("drain_timeout", 64'(sbq.size()), 64'(0));
   endtask

   always @(posedge clk) begin
      #1;
      if (rand_rdy) norm_ready_i = ($urandom_range(0, 3) != 0);
   end

   // Monitor: first valid cycle pops and checks; later valid cycles check the result is held.
   always @(negedge clk) begin
      exp_t e;
      if (norm_valid_o && !rst) begin
         chk("ready_low_while_valid", 64'(norm_ready_o), 64'(0));
         if (!in_res) begin
            if (sbq.size() == 0) begin
               chk("unexpected_result", 64'(1), 64'(0));
            end else begin
               e = sbq.pop_front();
               chk("norm_o", norm_o, e.n);
               chk("norm_sh_o", 64'(norm_sh_o), 64'(e.s));
               chk("latency", 64'(cyc - e.acc), 64'(e.lat));
               chk("invariant", 64'($signed(norm_o) >>> norm_sh_o), e.x);
`ifdef NORM_SHIFT_ZERO_EN
               chk("norm_zero_o", 64'(norm_zero_o), 64'(e.z));
`endif
            end
            held_n = norm_o;
            held_s = norm_sh_o;
            in_res = 1;
         end else begin
            chk("held_norm_o", norm_o, held_n);
            chk("held_norm_sh_o", 64'(norm_sh_o), 64'(held_s));
         end
         if (norm_ready_i) begin
            in_res = 0;
            last_handoff = cyc + 1;
            n_done++;
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      int   acc_edge;
      int   t;
      logic [WIDTH-1:0] r;
      rst = 1'b1;
      norm_valid_i = 1'b0;
      norm_i = '0;
      norm_ready_i = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_ready", 64'(norm_ready_o), 64'(1));
      chk("rst_valid", 64'(norm_valid_o), 64'(0));
      chk("rst_norm_o", norm_o, 64'(0));
      chk("rst_sh", 64'(norm_sh_o), 64'(0));
`ifdef NORM_SHIFT_ZERO_EN
      chk("rst_zero", 64'(norm_zero_o), 64'(0));
`endif

      // Directed vectors with hand-derived expectations.
      send_exp(vec(64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 0, 1));
      wait_drain(100);
      send_exp(vec(64'h0000_0000_0000_0001, 64'h4000_0000_0000_0000, 62, 16));
      wait_drain(100);
      send_exp(vec(64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 63, 16));
      wait_drain(100);
      send_exp(vec(64'hFF00_0000_0000_0000, 64'h8000_0000_0000_0000, 7, 2));
      wait_drain(100);
      e = vec(64'h0, 64'h0, 63, 16);
`ifdef NORM_SHIFT_ZERO_EN
      e.lat = 1;
      e.z   = 1'b1;
`endif
      send_exp(e);
      wait_drain(100);
      send_exp(vec(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 0, 1));
      wait_drain(100);

      // Backpressure, with a second operand held on the input throughout.
      norm_ready_i = 1'b0;
      send_exp(vec(64'h00FF_0000_0000_0000, 64'h7F80_0000_0000_0000, 7, 2));
      norm_valid_i = 1'b1;
      norm_i = 64'h0000_0000_1234_5678;
      t = 0;
      while (!norm_valid_o && t < 50) begin
         @(negedge clk);
         t++;
      end
      repeat (5) @(negedge clk);
      @(posedge clk); #1;
      norm_ready_i = 1'b1;
      hold_accept(model(64'h0000_0000_1234_5678));
      acc_edge = sbq.size() > 0 ? sbq[$].acc : 0;
      chk("second_accept_after_handoff", 64'(acc_edge > last_handoff), 64'(1));
      wait_drain(100);

      // Reset mid-BUSY discards the operand.
      send(64'h1);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      void'(sbq.pop_back());
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("abort_valid", 64'(norm_valid_o), 64'(0));
      chk("abort_ready", 64'(norm_ready_o), 64'(1));
      chk("abort_norm_o", norm_o, 64'(0));
      chk("abort_sh", 64'(norm_sh_o), 64'(0));
      repeat (30) @(negedge clk);
      chk("abort_no_result", 64'(n_done), 64'(8));

      // Random sweep: varied sign-run lengths, random downstream stalls.
      rand_rdy = 1;
      for (int i = 0; i < 2500; i++) begin
         r = {$urandom, $urandom};
         r = WIDTH'($signed(r) >>> $urandom_range(0, WIDTH - 1));
         if ($urandom_range(0, 3) == 0) r = r ^ (64'(1) << $urandom_range(0, WIDTH - 1));
         send(r);
      end
      rand_rdy = 0;
      #1 norm_ready_i = 1'b1;
      wait_drain(200);
      chk("scoreboard_empty", 64'(sbq.size()), 64'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
